receive_parser: RTL and testbench

- Input-port receive stage sitting directly downstream of the per-port packet sender.
- Consumes the sender's wr_sop/wr_vld/wr_data/wr_eop stream, extracts the header word {dest, priority, length}, and store-and-forward buffers the payload in a single-packet buffer.
- Checks the packet for framing errors; good packets are presented to the switch fabric with a req/grant handshake and then replayed. Bad packets are dropped and counted.

---
 rtl/receive_parser.sv | 156 +++++++++++++++
 tb/tb_receive_parser.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/receive_parser.sv
// Input-port receive stage: decodes the header, store-and-forward buffers one packet,
// drops framing errors and replays good packets to the fabric after a req/grant handshake.
module receive_parser #(
    parameter  int DATA_WIDTH      = 32,
    parameter  int PORT_NUB_TOTAL  = 16,
    parameter  int PRIORITY        = 8,
    parameter  int DATA_LENGTH_MAX = 1024,
    localparam int WIDTH_SEL       = $clog2(PORT_NUB_TOTAL),
    localparam int WIDTH_PRIORITY  = $clog2(PRIORITY),
    localparam int WIDTH_LENGTH    = $clog2(DATA_LENGTH_MAX)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      wr_sop,
    input  logic                      wr_eop,
    input  logic                      wr_vld,
    input  logic [DATA_WIDTH-1:0]     wr_data,
    output logic                      rx_ready,
    output logic                      out_req,
    output logic [WIDTH_SEL-1:0]      out_dest,
    output logic [WIDTH_PRIORITY-1:0] out_priority,
    output logic [WIDTH_LENGTH-1:0]   out_length,
    input  logic                      in_grant,
    output logic                      out_vld,
    output logic [DATA_WIDTH-1:0]     out_data,
    output logic                      out_last,
    output logic                      pkt_err,
    output logic [15:0]               err_cnt
);

    typedef enum logic [2:0] {
        S_IDLE, S_HDR, S_DATA, S_CHECK, S_REQ, S_OUT, S_DROP
    } state_t;

    state_t state, state_next;

    logic [WIDTH_SEL-1:0]      hdr_dest;
    logic [WIDTH_PRIORITY-1:0] hdr_priority;
    logic [WIDTH_LENGTH-1:0]   hdr_length;
    logic [WIDTH_LENGTH-1:0]   wcnt;
    logic                      overflow;
    logic [WIDTH_LENGTH-1:0]   out_idx;
    logic [WIDTH_LENGTH-1:0]   rd_addr;
    logic [DATA_WIDTH-1:0]     rd_q;
    logic [DATA_WIDTH-1:0]     mem [DATA_LENGTH_MAX];

    logic pkt_good;
    logic last_word;
    logic wr_en;
    logic err_inc;
    logic restart;

    assign pkt_good  = (hdr_length != '0) && (wcnt == hdr_length) && !overflow;
    assign last_word = (state == S_OUT) && (out_idx == hdr_length - 1'b1);
    // A sop mid-payload aborts the current packet and begins the next one at once.
    assign restart   = wr_sop && ((state == S_IDLE) || (state == S_DATA));
    assign wr_en     = (state == S_DATA) && wr_vld && !wr_sop && (wcnt != hdr_length);
    assign rd_addr   = (state == S_OUT) ? WIDTH_LENGTH'(out_idx + 1'b1) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state always uses non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves a
        // signal unassigned and no latch is inferred.
        state_next = state;
        rx_ready   = 1'b0;
        out_req    = 1'b0;
        out_vld    = 1'b0;
        pkt_err    = 1'b0;
        err_inc    = 1'b0;
        unique case (state)
            S_IDLE: begin
                rx_ready = 1'b1;
                if (wr_sop) state_next = S_HDR;
            end
            S_HDR: begin
                if (wr_eop)      state_next = S_DROP;
                else if (wr_vld) state_next = S_DATA;
            end
            S_DATA: begin
                if (wr_sop) begin
                    state_next = S_HDR;
                    pkt_err    = 1'b1;
                    err_inc    = 1'b1;
                end else if (wr_eop) begin
                    state_next = S_CHECK;
                end
            end
            S_CHECK: state_next = pkt_good ? S_REQ : S_DROP;
            S_REQ: begin
                out_req = 1'b1;
                pkt_err = wr_sop || wr_vld;
                if (in_grant) state_next = S_OUT;
            end
            S_OUT: begin
                out_vld = 1'b1;
                pkt_err = wr_sop || wr_vld;
                if (last_word) state_next = S_IDLE;
            end
            S_DROP: begin
                pkt_err    = 1'b1;
                err_inc    = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hdr_dest     <= '0;
            hdr_priority <= '0;
            hdr_length   <= '0;
            wcnt         <= '0;
            overflow     <= 1'b0;
            out_idx      <= '0;
            err_cnt      <= '0;
        end else begin
            if (restart) begin
                wcnt     <= '0;
                overflow <= 1'b0;
            end else if ((state == S_DATA) && wr_vld) begin
                if (wcnt != hdr_length) wcnt     <= wcnt + 1'b1;
                else                    overflow <= 1'b1;
            end
            if ((state == S_HDR) && wr_vld) begin
                hdr_length   <= wr_data[WIDTH_LENGTH-1:0];
                hdr_priority <= wr_data[WIDTH_LENGTH +: WIDTH_PRIORITY];
                hdr_dest     <= wr_data[WIDTH_LENGTH+WIDTH_PRIORITY +: WIDTH_SEL];
            end
            if (state == S_OUT) out_idx <= out_idx + 1'b1;
            else                out_idx <= '0;
            if (err_inc && (err_cnt != 16'hFFFF)) err_cnt <= err_cnt + 1'b1;
        end
    end

    // NOTE: the payload buffer is deliberately not reset; the header and counters gate
    // every use of it, and a reset port would prevent mapping it onto block RAM.
    // The read is registered one word ahead, so word 0 is fetched while still in REQ.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wcnt] <= wr_data;
        rd_q <= mem[rd_addr];
    end

    assign out_data     = out_vld ? rd_q : '0;
    assign out_last     = last_word;
    assign out_dest     = ((state == S_REQ) || (state == S_OUT)) ? hdr_dest     : '0;
    assign out_priority = ((state == S_REQ) || (state == S_OUT)) ? hdr_priority : '0;
    assign out_length   = ((state == S_REQ) || (state == S_OUT)) ? hdr_length   : '0;

endmodule

// File: tb/tb_receive_parser.sv
// Self-checking bench for receive_parser: directed and random packets compared against
// a packet-level model (good iff length != 0 and exactly length payload words arrived).
module tb_receive_parser;

    logic        clk;
    logic        rst_n;
    logic        wr_sop, wr_eop, wr_vld;
    logic [31:0] wr_data;
    logic        rx_ready, out_req, in_grant, out_vld, out_last, pkt_err;
    logic [3:0]  out_dest;
    logic [2:0]  out_priority;
    logic [9:0]  out_length;
    logic [31:0] out_data;
    logic [15:0] err_cnt;

    int total = 0;
    int bad   = 0;
    int exp_err = 0;
    logic [31:0] sent_q [$];

    receive_parser dut (
        .clk(clk), .rst_n(rst_n),
        .wr_sop(wr_sop), .wr_eop(wr_eop), .wr_vld(wr_vld), .wr_data(wr_data),
        .rx_ready(rx_ready), .out_req(out_req), .out_dest(out_dest),
        .out_priority(out_priority), .out_length(out_length), .in_grant(in_grant),
        .out_vld(out_vld), .out_data(out_data), .out_last(out_last),
        .pkt_err(pkt_err), .err_cnt(err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drives one packet (optionally continuing after a sop already driven) and checks
    // either the full req/grant/replay sequence or the drop, depending on the model.
    task automatic run_pkt(input logic [3:0] d, input logic [2:0] p, input logic [9:0] len,
                           input int nwords, input int gdelay, input bit skip_sop);
        logic [31:0] h;
        logic [31:0] w;
        bit good;
        h = $urandom;
        h[9:0]   = len;
        h[12:10] = p;
        h[16:13] = d;
        sent_q = {};
        if (!skip_sop) begin
            @(negedge clk);
            check("rdy_before_sop", rx_ready, 1);
            wr_sop = 1'b1;
        end
        @(negedge clk);
        wr_sop = 1'b0;
        check("rdy_in_hdr", rx_ready, 0);
        wr_vld  = 1'b1;
        wr_data = h;
        for (int i = 0; i < nwords; i++) begin
            @(negedge clk);
            w = $urandom;
            sent_q.push_back(w);
            wr_data = w;
        end
        @(negedge clk);
        wr_vld  = 1'b0;
        wr_data = '0;
        wr_eop  = 1'b1;
        @(negedge clk);
        wr_eop = 1'b0;
        check("req_in_check", out_req, 0);
        @(negedge clk);
        good = (len != 0) && (nwords == int'(len));
        if (good) begin
            for (int k = 0; k <= gdelay; k++) begin
                check("req_held", out_req, 1);
                check("dest", out_dest, d);
                check("prio", out_priority, p);
                check("len", out_length, len);
                check("rdy_in_req", rx_ready, 0);
                check("err_in_req", pkt_err, 0);
                if (k < gdelay) @(negedge clk);
            end
            in_grant = 1'b1;
            @(negedge clk);
            in_grant = 1'b0;
            check("req_drop", out_req, 0);
            for (int i = 0; i < int'(len); i++) begin
                check("out_vld", out_vld, 1);
                check("out_data", out_data, sent_q[i]);
                check("out_last", out_last, (i == int'(len) - 1) ? 1 : 0);
                @(negedge clk);
            end
            check("vld_after", out_vld, 0);
            check("rdy_after", rx_ready, 1);
            check("errcnt_good", err_cnt, exp_err);
        end else begin
            check("drop_err", pkt_err, 1);
            check("drop_noreq", out_req, 0);
            exp_err++;
            @(negedge clk);
            check("drop_err_pulse", pkt_err, 0);
            check("drop_cnt", err_cnt, exp_err);
            check("drop_rdy", rx_ready, 1);
        end
    endtask

    initial begin
        int len;
        int nw;
        wr_sop = 0; wr_eop = 0; wr_vld = 0; wr_data = 0; in_grant = 0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_rdy", rx_ready, 1);
        check("rst_req", out_req, 0);
        check("rst_vld", out_vld, 0);
        check("rst_data", out_data, 0);
        check("rst_last", out_last, 0);
        check("rst_err", pkt_err, 0);
        check("rst_cnt", err_cnt, 0);
        check("rst_dest", out_dest, 0);
        rst_n = 1'b1;

        // grant outside REQ and a stray eop/vld in IDLE must be ignored
        in_grant = 1'b1; wr_vld = 1'b1; wr_eop = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_stray_vld", out_vld, 0);
        check("idle_stray_err", err_cnt, 0);
        check("idle_stray_rdy", rx_ready, 1);
        in_grant = 1'b0; wr_vld = 1'b0; wr_eop = 1'b0;

        run_pkt(4'd3, 3'd5, 10'd4, 4, 0, 0);      // good packet
        run_pkt(4'd1, 3'd2, 10'd6, 4, 0, 0);      // short packet
        run_pkt(4'd7, 3'd0, 10'd0, 0, 0, 0);      // zero length
        run_pkt(4'd2, 3'd1, 10'd3, 5, 0, 0);      // overflow
        run_pkt(4'd9, 3'd7, 10'd5, 5, 20, 0);     // grant delay
        run_pkt(4'd4, 3'd3, 10'd1, 1, 0, 0);      // back-to-back
        run_pkt(4'd5, 3'd6, 10'd8, 8, 0, 0);

        // eop before the header word
        @(negedge clk);
        wr_sop = 1'b1;
        @(negedge clk);
        wr_sop = 1'b0; wr_eop = 1'b1;
        @(negedge clk);
        wr_eop = 1'b0;
        check("hdr_eop_err", pkt_err, 1);
        exp_err++;
        @(negedge clk);
        check("hdr_eop_cnt", err_cnt, exp_err);

        // sop mid-payload drops the packet and starts the next one immediately
        @(negedge clk);
        wr_sop = 1'b1;
        @(negedge clk);
        wr_sop = 1'b0; wr_vld = 1'b1; wr_data = 32'h0000_0005;
        repeat (2) begin
            @(negedge clk);
            wr_data = $urandom;
        end
        @(negedge clk);
        wr_vld = 1'b0; wr_sop = 1'b1;
        #1 check("abort_err", pkt_err, 1);
        exp_err++;
        run_pkt(4'd11, 3'd4, 10'd3, 3, 1, 1);

        for (int r = 0; r < 8; r++) begin
            len = $urandom_range(1, 16);
            case ($urandom_range(0, 3))
                0, 1:    nw = len;
                2:       nw = len - 1;
                default: nw = len + $urandom_range(1, 2);
            endcase
            run_pkt(4'($urandom), 3'($urandom), 10'(len), nw, $urandom_range(0, 3), 0);
        end

        run_pkt(4'd15, 3'd7, 10'd1023, 1023, 2, 0);   // largest length

        // asynchronous reset in the middle of the payload
        @(negedge clk);
        wr_sop = 1'b1;
        @(negedge clk);
        wr_sop = 1'b0; wr_vld = 1'b1; wr_data = 32'h0000_0005;
        repeat (3) begin
            @(negedge clk);
            wr_data = $urandom;
        end
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_rdy", rx_ready, 1);
        check("mid_rst_cnt", err_cnt, 0);
        check("mid_rst_err", pkt_err, 0);
        check("mid_rst_req", out_req, 0);
        check("mid_rst_vld", out_vld, 0);
        wr_vld = 1'b0; wr_data = '0;
        exp_err = 0;
        @(negedge clk);
        rst_n = 1'b1;
        run_pkt(4'd6, 3'd2, 10'd6, 6, 0, 0);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
